shreg_load_arbiter: RTL and testbench

//  Shares one WIDTH-bit parallel-load shift register (io_in/io_enable/io_out datapath) among NREQ requesters.

---
 rtl/shreg_load_arbiter_if.sv | 43 ++++
 rtl/shreg_load_arbiter.sv | 132 +++++++++++++
 tb/tb_shreg_load_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shreg_load_arbiter_if.sv
// Bundle between requesters, the arbiter and the shared
// parallel-load shift register.
interface shreg_load_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       io_req_valid;
  logic [NREQ-1:0]       io_req_ready;
  logic [NREQ*WIDTH-1:0] io_req_data;
  logic [WIDTH-1:0]      io_reg_in;
  logic                  io_reg_enable;
  logic [WIDTH-1:0]      io_reg_out;
  logic                  io_busy;
  logic                  io_rsp_valid;
  logic [WIDTH-1:0]      io_rsp_data;
  logic [1:0]            io_rsp_id;

  modport master (
    output io_req_valid,
    output io_req_data,
    output io_reg_out,
    input  io_req_ready,
    input  io_reg_in,
    input  io_reg_enable,
    input  io_busy,
    input  io_rsp_valid,
    input  io_rsp_data,
    input  io_rsp_id
  );

  modport slave (
    input  io_req_valid,
    input  io_req_data,
    input  io_reg_out,
    output io_req_ready,
    output io_reg_in,
    output io_reg_enable,
    output io_busy,
    output io_rsp_valid,
    output io_rsp_data,
    output io_rsp_id
  );
endinterface

// File: rtl/shreg_load_arbiter.sv
// Round-robin owner of a shared parallel-load shift register:
// load one word, hold it, read it back as a tagged response.
module shreg_load_arbiter #(
  parameter int NREQ        = 2,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 3
) (
  input logic clk,
  input logic reset,
  shreg_load_arbiter_if.slave bus
);

  localparam int CW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_last;
  logic [1:0]      r_idx;
  logic [1:0]      w_idx;
  int              w_sel;
  int              w_j;
  logic [NREQ-1:0] w_grant;
  logic            w_hs;
  logic            w_rsp;
  logic [WIDTH-1:0] w_word;

  logic             r_en;
  logic             r_busy;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_reg_in;
  logic [WIDTH-1:0] r_rsp_data;
  logic [1:0]       r_rsp_id;

  // Search starts just past the previous winner.
  always_comb begin
    w_grant = '0;
    w_hs    = 1'b0;
    w_sel   = 0;
    w_j     = 0;
    if (r_state == IDLE) begin
      for (int k = 1; k <= NREQ; k++) begin
        w_j = (int'(r_last) + k) % NREQ;
        if (!w_hs && bus.io_req_valid[w_j]) begin
          w_hs         = 1'b1;
          w_sel        = w_j;
          w_grant[w_j] = 1'b1;
        end
      end
    end
  end

  assign w_idx  = 2'(w_sel);
  assign w_word = bus.io_req_data[w_sel*WIDTH +: WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 2'(NREQ - 1);
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_last <= w_idx;
        r_idx  <= w_idx;
      end
      if (r_state == LOAD)
        r_cnt <= CW'(HOLD_CYCLES - 1);
      else if (r_state == HOLD && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_hs) w_next = LOAD;
      LOAD:    w_next = HOLD;
      HOLD:    if (r_cnt == '0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Response register is armed one cycle early so the
  // strobe lands in the final hold cycle.
  always_comb begin
    w_rsp = 1'b0;
    unique case (1'b1)
      (r_state == LOAD): w_rsp = (HOLD_CYCLES == 1);
      (r_state == HOLD): w_rsp = (r_cnt == CW'(1));
      default:           w_rsp = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en        <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_reg_in    <= '0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
    end else begin
      r_en        <= w_hs;
      r_busy      <= (w_next != IDLE);
      r_rsp_valid <= w_rsp;
      if (w_hs)
        r_reg_in <= w_word;
      if (w_rsp) begin
        r_rsp_data <= bus.io_reg_out;
        r_rsp_id   <= r_idx;
      end
    end
  end

  assign bus.io_req_ready  = w_grant;
  assign bus.io_reg_in     = r_reg_in;
  assign bus.io_reg_enable = r_en;
  assign bus.io_busy       = r_busy;
  assign bus.io_rsp_valid  = r_rsp_valid;
  assign bus.io_rsp_data   = r_rsp_data;
  assign bus.io_rsp_id     = r_rsp_id;

endmodule

// File: tb/tb_shreg_load_arbiter.sv
// Directed bench: two-requester and four-requester arbiters,
// each backed by a simple parallel-load register model.
module tb_shreg_load_arbiter;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  shreg_load_arbiter_if #(.NREQ(2), .WIDTH(8)) if2 ();
  shreg_load_arbiter_if #(.NREQ(4), .WIDTH(8)) if4 ();

  shreg_load_arbiter #(
    .NREQ(2), .WIDTH(8), .HOLD_CYCLES(3)
  ) dut2 (
    .clk(clk), .reset(reset), .bus(if2.slave)
  );

  shreg_load_arbiter #(
    .NREQ(4), .WIDTH(8), .HOLD_CYCLES(3)
  ) dut4 (
    .clk(clk), .reset(reset), .bus(if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) if2.io_reg_out <= '0;
    else if (if2.io_reg_enable) if2.io_reg_out <= if2.io_reg_in;

  always @(posedge clk or posedge reset)
    if (reset) if4.io_reg_out <= '0;
    else if (if4.io_reg_enable) if4.io_reg_out <= if4.io_reg_in;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    if2.io_req_data  = 16'h00A5;
    if2.io_req_valid = 2'b01;
    @(negedge clk);
    #1;
    checks++;
    if (if2.io_reg_enable !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_en got %b want 1", if2.io_reg_enable);
    end
    #2;
    reset = 1'b1;
    if2.io_req_valid = 2'b00;
    #1;
    checks++;
    if (if2.io_reg_enable !== 1'b0 || if2.io_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_en_busy got %b%b want 00",
               if2.io_reg_enable, if2.io_busy);
    end
    checks++;
    if (if2.io_reg_in !== 8'h00 || if2.io_rsp_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_data got %h %h want 00 00",
               if2.io_reg_in, if2.io_rsp_data);
    end
    checks++;
    if (if2.io_rsp_valid !== 1'b0 || if2.io_rsp_id !== 2'd0 ||
        if2.io_req_ready !== 2'b00) begin
      errors++;
      $display("FAIL rst_rsp got v=%b id=%0d rdy=%b want 0 0 00",
               if2.io_rsp_valid, if2.io_rsp_id, if2.io_req_ready);
    end
    checks++;
    if (if4.io_busy !== 1'b0 || if4.io_req_ready !== 4'b0000 ||
        if4.io_reg_in !== 8'h00) begin
      errors++;
      $display("FAIL rst_dut4 got busy=%b rdy=%b in=%h want 0 0000 00",
               if4.io_busy, if4.io_req_ready, if4.io_reg_in);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    if2.io_req_data  = 16'h00A5;
    if2.io_req_valid = 2'b01;
    #1;
    checks++;
    if (if2.io_req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_grant got %b want 01", if2.io_req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (if2.io_reg_enable !== 1'b1 || if2.io_reg_in !== 8'hA5 ||
        if2.io_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_load got en=%b in=%h busy=%b want 1 a5 1",
               if2.io_reg_enable, if2.io_reg_in, if2.io_busy);
    end
    for (int i = 2; i <= 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (if2.io_reg_enable !== 1'b0 || if2.io_rsp_valid !== 1'b0 ||
          if2.io_req_ready !== 2'b00 || if2.io_reg_in !== 8'hA5) begin
        errors++;
        $display("FAIL single_hold%0d got en=%b rv=%b rdy=%b in=%h",
                 i, if2.io_reg_enable, if2.io_rsp_valid,
                 if2.io_req_ready, if2.io_reg_in);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (if2.io_rsp_valid !== 1'b1 || if2.io_rsp_data !== 8'hA5 ||
        if2.io_rsp_id !== 2'd0 || if2.io_req_ready !== 2'b00) begin
      errors++;
      $display("FAIL single_rsp got v=%b d=%h id=%0d rdy=%b want 1 a5 0 00",
               if2.io_rsp_valid, if2.io_rsp_data, if2.io_rsp_id,
               if2.io_req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (if2.io_rsp_valid !== 1'b0 || if2.io_busy !== 1'b0 ||
        if2.io_req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_next got rv=%b busy=%b rdy=%b want 0 0 01",
               if2.io_rsp_valid, if2.io_busy, if2.io_req_ready);
    end
    if2.io_req_valid = 2'b00;
    #1;
  endtask

  task automatic test_fairness();
    logic [1:0] want;
    logic [7:0] wdat;
    do_reset();
    @(negedge clk);
    if2.io_req_data  = 16'h2211;
    if2.io_req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      want = (n % 2 == 0) ? 2'b01 : 2'b10;
      wdat = (n % 2 == 0) ? 8'h11 : 8'h22;
      #1;
      checks++;
      if (if2.io_req_ready !== want) begin
        errors++;
        $display("FAIL fair_grant%0d got %b want %b",
                 n, if2.io_req_ready, want);
      end
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (if2.io_rsp_valid !== 1'b1 || if2.io_rsp_id !== 2'(n % 2) ||
          if2.io_rsp_data !== wdat) begin
        errors++;
        $display("FAIL fair_rsp%0d got v=%b id=%0d d=%h want 1 %0d %h",
                 n, if2.io_rsp_valid, if2.io_rsp_id, if2.io_rsp_data,
                 n % 2, wdat);
      end
      if (n == 3) if2.io_req_valid = 2'b00;
      else @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    if4.io_req_data  = 32'h3C00000F;
    if4.io_req_valid = 4'b1000;
    #1;
    checks++;
    if (if4.io_req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_grant3 got %b want 1000", if4.io_req_ready);
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (if4.io_rsp_valid !== 1'b1 || if4.io_rsp_id !== 2'd3 ||
        if4.io_rsp_data !== 8'h3C) begin
      errors++;
      $display("FAIL wrap_rsp3 got v=%b id=%0d d=%h want 1 3 3c",
               if4.io_rsp_valid, if4.io_rsp_id, if4.io_rsp_data);
    end
    if4.io_req_valid = 4'b0001;
    @(negedge clk);
    #1;
    checks++;
    if (if4.io_req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_grant0 got %b want 0001", if4.io_req_ready);
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (if4.io_rsp_valid !== 1'b1 || if4.io_rsp_id !== 2'd0 ||
        if4.io_rsp_data !== 8'h0F) begin
      errors++;
      $display("FAIL wrap_rsp0 got v=%b id=%0d d=%h want 1 0 0f",
               if4.io_rsp_valid, if4.io_rsp_id, if4.io_rsp_data);
    end
    if4.io_req_valid = 4'b0000;
  endtask

  task automatic test_drop_late();
    @(negedge clk);
    if2.io_req_data  = 16'hC35A;
    if2.io_req_valid = 2'b01;
    #1;
    checks++;
    if (if2.io_req_ready !== 2'b01) begin
      errors++;
      $display("FAIL drop_grant0 got %b want 01", if2.io_req_ready);
    end
    @(negedge clk);
    if2.io_req_valid = 2'b11;
    #1;
    checks++;
    if (if2.io_req_ready !== 2'b00 || if2.io_reg_enable !== 1'b1) begin
      errors++;
      $display("FAIL drop_load got rdy=%b en=%b want 00 1",
               if2.io_req_ready, if2.io_reg_enable);
    end
    @(negedge clk);
    if2.io_req_valid = 2'b10;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (if2.io_rsp_valid !== 1'b1 || if2.io_rsp_id !== 2'd0 ||
        if2.io_rsp_data !== 8'h5A) begin
      errors++;
      $display("FAIL drop_rsp got v=%b id=%0d d=%h want 1 0 5a",
               if2.io_rsp_valid, if2.io_rsp_id, if2.io_rsp_data);
    end
    @(negedge clk);
    #1;
    checks++;
    if (if2.io_req_ready !== 2'b10) begin
      errors++;
      $display("FAIL late_grant1 got %b want 10", if2.io_req_ready);
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (if2.io_rsp_valid !== 1'b1 || if2.io_rsp_id !== 2'd1 ||
        if2.io_rsp_data !== 8'hC3) begin
      errors++;
      $display("FAIL late_rsp got v=%b id=%0d d=%h want 1 1 c3",
               if2.io_rsp_valid, if2.io_rsp_id, if2.io_rsp_data);
    end
    if2.io_req_valid = 2'b00;
  endtask

  task automatic test_reset_hold();
    @(negedge clk);
    if2.io_req_data  = 16'h7700;
    if2.io_req_valid = 2'b10;
    #1;
    checks++;
    if (if2.io_req_ready !== 2'b10) begin
      errors++;
      $display("FAIL rh_grant got %b want 10", if2.io_req_ready);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (if2.io_busy !== 1'b1 || if2.io_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rh_pre got busy=%b rv=%b want 1 0",
               if2.io_busy, if2.io_rsp_valid);
    end
    #2;
    reset = 1'b1;
    if2.io_req_valid = 2'b00;
    #1;
    checks++;
    if (if2.io_busy !== 1'b0 || if2.io_reg_in !== 8'h00 ||
        if2.io_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rh_abort got busy=%b in=%h rv=%b want 0 00 0",
               if2.io_busy, if2.io_reg_in, if2.io_rsp_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (if2.io_rsp_valid !== 1'b0 || if2.io_busy !== 1'b0) begin
      errors++;
      $display("FAIL rh_norsp got rv=%b busy=%b want 0 0",
               if2.io_rsp_valid, if2.io_busy);
    end
    if2.io_req_valid = 2'b11;
    #1;
    checks++;
    if (if2.io_req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rh_first got %b want 01", if2.io_req_ready);
    end
    if2.io_req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (if2.io_rsp_valid !== 1'b0 || if2.io_reg_enable !== 1'b0) begin
        errors++;
        $display("FAIL rh_quiet%0d got rv=%b en=%b want 0 0",
                 i, if2.io_rsp_valid, if2.io_reg_enable);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    if2.io_req_valid = '0;
    if2.io_req_data  = '0;
    if4.io_req_valid = '0;
    if4.io_req_data  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_drop_late();
    test_reset_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
